// File: rtl/data_memory_hs_pkg.sv
// Shared definitions for the data memory block: access size codes, FSM state
// encoding and the upper bound on the configurable read latency.
package data_memory_hs_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b11;

  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/data_memory_hs_lane_align.sv
// Combinational lane logic for the data memory.
//   mem_word    : current contents of the addressed word
//   wdata       : right-aligned store data
//   size, lane  : access size code and byte-address bits [1:0]
//   is_unsigned : zero-extend (1) or sign-extend (0) sub-word loads
//   merged      : mem_word with the selected lanes replaced by store data
//   load_data   : selected lane(s) extended to 32 bits
//   fault       : misaligned access or reserved size code
module data_memory_hs_lane_align
  import data_memory_hs_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    merged    = mem_word;
    load_data = '0;
    fault     = 1'b0;
    half_sel  = lane[1] ? mem_word[31:16] : mem_word[15:0];
    byte_sel  = mem_word[{lane, 3'b000} +: 8];
    case (size)
      SIZE_WORD: begin
        fault     = (lane != 2'b00);
        merged    = wdata;
        load_data = mem_word;
      end
      SIZE_HALF: begin
        fault = lane[0];
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
        load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      end
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Word-organised data RAM behind a valid/ready request / one-cycle response
// handshake, with byte/half/word access, load extension, misalignment faults
// and optional zeroing of the array after reset.
//   clk, rst                    : clock, synchronous active-high reset
//   Req_Valid/Req_Ready         : request handshake
//   Req_Write/Size/Unsigned     : access type
//   Req_Addr, Req_Wdata         : byte address, right-aligned store data
//   Resp_Valid                  : one-cycle completion pulse
//   Resp_Rdata, Resp_Fault      : load data (0 for stores/faults), fault flag
//   Init_Done                   : array ready for use
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_INIT | clearing one word per cycle, requests blocked
// ST_IDLE | ready to accept a request
// ST_WAIT | access done, counting down the remaining read latency
// ST_RESP | Resp_Valid pulse, back to ST_IDLE next cycle
module data_memory_hs
  import data_memory_hs_pkg::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Unsigned,
  input  logic [ADDR_WIDTH-1:0] Req_Addr,
  input  logic [31:0]           Req_Wdata,
  output logic                  Resp_Valid,
  output logic [31:0]           Resp_Rdata,
  output logic                  Resp_Fault,
  output logic                  Init_Done
);

  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WW;
  localparam int LAT_W = $clog2(MAX_READ_LATENCY);
  localparam logic [WW-1:0] CLR_LAST = WW'(DEPTH - 1);

  logic [31:0]      mem [0:DEPTH-1];
  state_t           state, state_nxt;
  logic [WW-1:0]    clr_idx;
  logic [LAT_W-1:0] lat_cnt;
  logic [31:0]      pend_rdata;
  logic             pend_fault;

  logic [WW-1:0] word_idx;
  logic [31:0]   old_word, merged, load_data, acc_rdata;
  logic          fault, accept;

  assign word_idx  = Req_Addr[ADDR_WIDTH-1:2];
  assign old_word  = mem[word_idx];
  assign accept    = (state == ST_IDLE) && Init_Done && Req_Valid;
  assign acc_rdata = (Req_Write || fault) ? 32'h0 : load_data;

  data_memory_hs_lane_align u_lane (
    .mem_word    (old_word),
    .wdata       (Req_Wdata),
    .size        (Req_Size),
    .lane        (Req_Addr[1:0]),
    .is_unsigned (Req_Unsigned),
    .merged      (merged),
    .load_data   (load_data),
    .fault       (fault)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Req_Ready  = 1'b0;
    Resp_Valid = 1'b0;
    case (state)
      ST_INIT: if (clr_idx == CLR_LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        Req_Ready = Init_Done;
        if (accept) state_nxt = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (lat_cnt == LAT_W'(1)) state_nxt = ST_RESP;
      ST_RESP: begin
        Resp_Valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx    <= '0;
      lat_cnt    <= '0;
      Init_Done  <= 1'b0;
      pend_rdata <= '0;
      pend_fault <= 1'b0;
      Resp_Rdata <= '0;
      Resp_Fault <= 1'b0;
    end else begin
      if (state == ST_INIT) clr_idx <= clr_idx + 1'b1;

      if (CLEAR_ON_RESET == 0)                        Init_Done <= 1'b1;
      else if (state == ST_INIT && clr_idx == CLR_LAST) Init_Done <= 1'b1;

      if (accept) begin
        lat_cnt    <= LAT_W'(READ_LATENCY - 1);
        pend_rdata <= acc_rdata;
        pend_fault <= fault;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      // ST_RESP is only ever entered from IDLE (latency 1) or WAIT; with
      // latency 1 the pending registers are not loaded yet, so bypass them.
      if (state_nxt == ST_RESP) begin
        Resp_Rdata <= (state == ST_IDLE) ? acc_rdata : pend_rdata;
        Resp_Fault <= (state == ST_IDLE) ? fault : pend_fault;
      end
    end
  end

  // Array has no reset so that contents survive rst when clearing is disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[clr_idx] <= 32'h0;
      else if (accept && Req_Write && !fault)
        mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
module tb_data_memory_hs;
  import data_memory_hs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  logic        a_ready, a_resp, a_fault, a_init;
  logic [31:0] a_rdata;
  logic        b_ready, b_resp, b_fault, b_init;
  logic [31:0] b_rdata;

  logic        cur_ready, cur_resp, cur_fault;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_resp  = sel ? b_resp  : a_resp;
  assign cur_fault = sel ? b_fault : a_fault;
  assign cur_rdata = sel ? b_rdata : a_rdata;

  data_memory_hs #(.ADDR_WIDTH(9), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .Req_Valid(req_valid & ~sel), .Req_Ready(a_ready),
    .Req_Write(req_write), .Req_Size(req_size), .Req_Unsigned(req_unsigned),
    .Req_Addr(req_addr), .Req_Wdata(req_wdata),
    .Resp_Valid(a_resp), .Resp_Rdata(a_rdata), .Resp_Fault(a_fault),
    .Init_Done(a_init)
  );

  data_memory_hs #(.ADDR_WIDTH(9), .READ_LATENCY(3), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst_b),
    .Req_Valid(req_valid & sel), .Req_Ready(b_ready),
    .Req_Write(req_write), .Req_Size(req_size), .Req_Unsigned(req_unsigned),
    .Req_Addr(req_addr), .Req_Wdata(req_wdata),
    .Resp_Valid(b_resp), .Resp_Rdata(b_rdata), .Resp_Fault(b_fault),
    .Init_Done(b_init)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic xfer(input bit b, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [8:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat);
    int guard;
    guard = 0;
    sel = b; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!cur_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!cur_resp && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = cur_rdata;
    flt = cur_fault;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_f;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat, n;

    // store / merge
    vecs.push_back('{1, SIZE_WORD, 0, 9'h010, 32'h11223344, 32'h0, 0});
    vecs.push_back('{1, SIZE_BYTE, 1, 9'h011, 32'hFFFFFFAA, 32'h0, 0});
    vecs.push_back('{1, SIZE_HALF, 0, 9'h012, 32'h1234BEEF, 32'h0, 0});
    vecs.push_back('{0, SIZE_WORD, 0, 9'h010, 32'h0, 32'hBEEFAA44, 0});
    // extension
    vecs.push_back('{1, SIZE_WORD, 0, 9'h020, 32'h80FF7F01, 32'h0, 0});
    vecs.push_back('{0, SIZE_BYTE, 0, 9'h022, 32'h0, 32'hFFFFFFFF, 0});
    vecs.push_back('{0, SIZE_BYTE, 1, 9'h021, 32'h0, 32'h0000007F, 0});
    vecs.push_back('{0, SIZE_HALF, 0, 9'h022, 32'h0, 32'hFFFF80FF, 0});
    vecs.push_back('{0, SIZE_HALF, 1, 9'h022, 32'h0, 32'h000080FF, 0});
    vecs.push_back('{0, SIZE_BYTE, 0, 9'h020, 32'h0, 32'h00000001, 0});
    vecs.push_back('{0, SIZE_BYTE, 1, 9'h023, 32'h0, 32'h00000080, 0});
    vecs.push_back('{0, SIZE_BYTE, 0, 9'h023, 32'h0, 32'hFFFFFF80, 0});
    vecs.push_back('{0, SIZE_HALF, 0, 9'h020, 32'h0, 32'h00007F01, 0});
    // faults (loads and stores), array must stay intact
    vecs.push_back('{0, SIZE_WORD, 0, 9'h021, 32'h0, 32'h0, 1});
    vecs.push_back('{0, SIZE_HALF, 0, 9'h023, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 2'b01,     0, 9'h020, 32'h0, 32'h0, 1});
    vecs.push_back('{1, SIZE_WORD, 0, 9'h022, 32'hDEADBEEF, 32'h0, 1});
    vecs.push_back('{1, SIZE_HALF, 0, 9'h021, 32'h0000FFFF, 32'h0, 1});
    vecs.push_back('{1, 2'b01,     0, 9'h020, 32'h00000000, 32'h0, 1});
    // top of address space
    vecs.push_back('{1, SIZE_WORD, 0, 9'h1FC, 32'hCAFEF00D, 32'h0, 0});
    vecs.push_back('{0, SIZE_HALF, 1, 9'h1FE, 32'h0, 32'h0000CAFE, 0});
    vecs.push_back('{0, SIZE_WORD, 1, 9'h020, 32'h0, 32'h80FF7F01, 0});

    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_WORD; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_ready", {31'b0, a_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, a_resp}, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_fault", {31'b0, a_fault}, 32'h0);
    chk("rst_init_done", {31'b0, a_init}, 32'h0);

    // clear takes DEPTH = 128 cycles
    rst_a = 1'b0;
    n = 0;
    while (!a_init && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 64) chk("init_ready_low", {31'b0, a_ready}, 32'h0);
    end
    chk("init_cycles", n, 128);

    xfer(0, 0, SIZE_WORD, 0, 9'h1FC, 32'h0, rd, flt, lat);
    chk("clr_lw_1fc", rd, 32'h0);
    xfer(0, 0, SIZE_WORD, 0, 9'h010, 32'h0, rd, flt, lat);
    chk("clr_lw_010", rd, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(0, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, flt, lat);
      chk($sformatf("v%0d_latency", i), lat, 1);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].exp_f});
    end

    // response is a single-cycle pulse and data is held afterwards
    @(negedge clk);
    chk("pulse_one_cycle", {31'b0, a_resp}, 32'h0);
    chk("ready_after_resp", {31'b0, a_ready}, 32'h1);
    repeat (2) @(negedge clk);
    chk("rdata_held", a_rdata, 32'h80FF7F01);

    // second instance: latency 3, no clear
    sel = 1'b1;
    chk("b_rst_init_done", {31'b0, b_init}, 32'h0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_init_one_cycle", {31'b0, b_init}, 32'h1);

    xfer(1, 1, SIZE_WORD, 0, 9'h000, 32'h01020304, rd, flt, lat);
    chk("b_sw_latency", lat, 3);

    // back-to-back with Req_Valid held high: accepts every 4 cycles
    @(negedge clk);
    req_write = 1'b1; req_size = SIZE_WORD; req_addr = 9'h000; req_wdata = 32'h01020304;
    req_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      chk($sformatf("b2b_ready_s%0d", s), {31'b0, b_ready}, {31'b0, (s % 4) == 0});
      chk($sformatf("b2b_resp_s%0d", s), {31'b0, b_resp}, {31'b0, (s % 4) == 3});
      @(negedge clk);
    end
    req_valid = 1'b0;

    xfer(1, 0, SIZE_WORD, 0, 9'h000, 32'h0, rd, flt, lat);
    chk("b_lw_latency", lat, 3);
    chk("b_lw_data", rd, 32'h01020304);

    // reset while waiting after a store
    @(negedge clk);
    n = 0;
    while (!b_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_write = 1'b1; req_size = SIZE_WORD; req_addr = 9'h040; req_wdata = 32'h5A5AA5A5;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b_in_wait_ready", {31'b0, b_ready}, 32'h0);
    rst_b = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("rst_wait_resp_s%0d", s), {31'b0, b_resp}, 32'h0);
      chk($sformatf("rst_wait_ready_s%0d", s), {31'b0, b_ready}, 32'h0);
    end
    chk("rst_wait_rdata", b_rdata, 32'h0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_wait_resp_after", {31'b0, b_resp}, 32'h0);
    xfer(1, 0, SIZE_WORD, 0, 9'h040, 32'h0, rd, flt, lat);
    chk("store_persists", rd, 32'h5A5AA5A5);
    chk("store_persists_fault", {31'b0, flt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
